// File: rtl/if_id_pkg.sv
// Shared definitions for the IF->ID fetch queue: word width, queue entry layout
// and the NOP encoding.
package if_id_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] NOP = 32'hE000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_id_queue_ram.sv
// Entry storage for the fetch queue: one synchronous write port, one asynchronous
// read port, contents are not reset.
module if_id_queue_ram #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF->ID fetch queue: captures {PC+4, instruction} each unfrozen cycle, hands entries
// to ID via valid/ready, freezes fetch when full, flushes on taken branch.
// Optional zero-latency pass-through when empty: define QUEUE_BYPASS_EN.
module if_id_fetch_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WORD_W = if_id_pkg::WORD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WORD_W-1:0]        if_pc,
  input  logic [WORD_W-1:0]        if_instruction,
  input  logic                     branch_taken,
  output logic                     freeze,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [WORD_W-1:0]        id_pc,
  output logic [WORD_W-1:0]        id_instruction,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count_q;
  logic                enq, deq, full, empty, bypass;
  logic [2*WORD_W-1:0] rd_data;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;

`ifdef QUEUE_BYPASS_EN
  assign bypass = empty && !branch_taken;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that ID takes immediately never enters storage.
  always_comb begin
    freeze         = full && !id_ready && !branch_taken;
    deq            = !empty && id_ready && !branch_taken;
    enq            = !freeze && !branch_taken && !(bypass && id_ready);
    id_valid       = !empty || bypass;
    id_pc          = '0;
    id_instruction = '0;
    if (!empty) begin
      id_pc          = rd_data[2*WORD_W-1:WORD_W];
      id_instruction = rd_data[WORD_W-1:0];
    end else if (bypass) begin
      id_pc          = if_pc;
      id_instruction = if_instruction;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (branch_taken) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (deq) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({enq, deq})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  if_id_queue_ram #(
    .DEPTH (DEPTH),
    .DATA_W(2 * WORD_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (enq),
    .waddr(wr_ptr),
    .wdata({if_pc, if_instruction}),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Scoreboard bench for if_id_fetch_queue: directed fetch/handshake/flush/reset
// sequences; a negedge monitor compares DUT outputs against the queued expectations.
module tb_if_id_fetch_queue;
  import if_id_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [WORD_W-1:0] if_pc, if_instruction;
  logic              branch_taken, freeze, id_valid, id_ready;
  logic [WORD_W-1:0] id_pc, id_instruction;
  logic [2:0]        count;

  always #5 clk = ~clk;

  if_id_fetch_queue #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_pc         (if_pc),
    .if_instruction(if_instruction),
    .branch_taken  (branch_taken),
    .freeze        (freeze),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_pc         (id_pc),
    .id_instruction(id_instruction),
    .count         (count)
  );

  typedef struct {
    fetch_entry_t e;
    int           vis;
  } sb_t;

  sb_t         sb[$];
  int          total = 0, bad = 0, cyc = 0, mcount = 0, exp_count = 0;
  logic [31:0] fpc = 32'd4, br_tgt = '0, ovr_instr = '0;
  bit          ovr_en = 0, active = 0, skip = 1, exp_freeze = 0, byp = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return NOP | {16'h0, pc[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // One fetch cycle: drive inputs after the edge and record what the monitor should see.
  task automatic step(input bit ready, input bit br, input bit rstv);
    bit   enq, deq;
    sb_t  t;
    @(posedge clk);
    #1;
    cyc++;
    rst            = rstv;
    id_ready       = ready;
    branch_taken   = br;
    if_pc          = fpc;
    if_instruction = ovr_en ? ovr_instr : instr_of(fpc);
    if (!rstv) begin
      skip   = 1;
      sb.delete();
      mcount = 0;
      fpc    = 32'd4;
    end else begin
      skip       = 0;
      exp_count  = mcount;
      exp_freeze = (mcount == DEPTH) && !ready && !br;
`ifdef QUEUE_BYPASS_EN
      byp = (mcount == 0) && !br;
`else
      byp = 0;
`endif
      if (br) begin
        sb.delete();
        mcount = 0;
        fpc    = br_tgt + 32'd4;
      end else begin
        deq = (mcount != 0) && ready;
        enq = !exp_freeze && !(byp && ready);
        if (enq) begin
          t.e.pc    = if_pc;
          t.e.instr = if_instruction;
          t.vis     = cyc + 1;
          sb.push_back(t);
        end
        mcount = mcount + int'(enq) - int'(deq);
        if (!exp_freeze) fpc = fpc + 32'd4;
      end
    end
    active = 1;
  endtask

  always @(negedge clk) begin
    if (active && !skip) begin
      chk("count", 32'(count), exp_count);
      chk("freeze", 32'(freeze), 32'(exp_freeze));
      if (!branch_taken) begin
        if (byp) begin
          chk("byp_valid", 32'(id_valid), 32'd1);
          chk("byp_pc", id_pc, if_pc);
          chk("byp_instr", id_instruction, if_instruction);
        end else if (sb.size() > 0 && sb[0].vis <= cyc) begin
          chk("valid", 32'(id_valid), 32'd1);
          chk("id_pc", id_pc, sb[0].e.pc);
          chk("id_instr", id_instruction, sb[0].e.instr);
          if (id_ready) void'(sb.pop_front());
        end else begin
          chk("empty_valid", 32'(id_valid), 32'd0);
          chk("empty_pc", id_pc, 32'd0);
          chk("empty_instr", id_instruction, 32'd0);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; id_ready = 1'b0; branch_taken = 1'b0;
    if_pc = '0; if_instruction = '0;
    step(0, 0, 0); step(0, 0, 0);
    // streaming with ID always ready
    for (int i = 0; i < 4; i++) step(1, 0, 1);
    // fill from empty, freeze once full
    step(0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1);
    // full queue, one ready cycle: dequeue and enqueue together
    step(1, 0, 1);
    step(0, 0, 1);
    // branch at count 3
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    fpc = 32'h40; br_tgt = 32'h40;
    step(1, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 1);
    // branch while full
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    br_tgt = 32'h100;
    step(0, 1, 1);
    step(0, 0, 1); step(1, 0, 1);
    // reset mid-stream while full, ready toggling
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    step(1, 0, 0); step(0, 0, 0);
    step(1, 0, 1); step(1, 0, 1); step(0, 0, 1);
    step(1, 0, 1); step(0, 0, 1); step(1, 0, 1);
    // empty queue, ready, specific instruction
    step(1, 0, 0);
    ovr_en = 1; ovr_instr = 32'hE3A0_0014;
    step(1, 0, 1);
    ovr_en = 0;
    step(1, 0, 1); step(1, 0, 1); step(0, 0, 1);
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
